// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one N-bit add/sub datapath
// among four requesters, with a tagged valid/ready result port.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   req[3:0]        level requests, bit i = requester i
//   a_bus, b_bus    operands, requester i at [i*N +: N]
//   sub_bus[3:0]    per-requester select: 1 = a - b, 0 = a + b
//   gnt[3:0]        one-hot pulse: winner's operands captured
//   busy            high whenever not idle
//   out, cout, ovf  result, carry out of MSB, signed overflow
//   out_id          requester owning the result
//   out_valid       result valid, held until out_ready
//   out_ready       consumer accept
//
// Option: ADDSUB_ARB_SAT_EN saturates out to the signed limit on ovf.
module addsub_arbiter #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] a_bus,
  input  logic [4*N-1:0] b_bus,
  input  logic [3:0]     sub_bus,
  output logic [3:0]     gnt,
  output logic           busy,
  output logic [N-1:0]   out,
  output logic           cout,
  output logic           ovf,
  output logic [1:0]     out_id,
  output logic           out_valid,
  input  logic           out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         r_state;
  logic [1:0]     r_last;
  logic [1:0]     r_win;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_sub;
  logic [3:0]     r_gnt;
  logic           r_busy;
  logic [N-1:0]   r_out;
  logic           r_cout;
  logic           r_ovf;
  logic [1:0]     r_out_id;
  logic           r_out_valid;

  logic [1:0]     w_win;
  logic [1:0]     w_idx;
  logic           w_found;
  logic [N-1:0]   w_bx;
  logic [N:0]     w_full;
  logic [N-1:0]   w_low;
  logic           w_cmsb;
  logic           w_ovf;
  logic [N-1:0]   w_res;

  // Scan last+1 .. last+4 (mod 4); the first active request wins.
  always_comb begin
    w_win   = r_last;
    w_idx   = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // a + (b ^ {N{sub}}) + sub; carry into the MSB comes from the
  // low N-1 bits alone.
  always_comb begin
    w_bx   = r_b ^ {N{r_sub}};
    w_full = {1'b0, r_a} + {1'b0, w_bx} + {{N{1'b0}}, r_sub};
    w_low  = {1'b0, r_a[N-2:0]} + {1'b0, w_bx[N-2:0]}
           + {{(N-1){1'b0}}, r_sub};
    w_cmsb = w_low[N-1];
    w_ovf  = w_cmsb ^ w_full[N];
    w_res  = w_full[N-1:0];
`ifdef ADDSUB_ARB_SAT_EN
    // On overflow both effective operands share the sign of a,
    // which is the sign of the true result.
    if (w_ovf) begin
      w_res = r_a[N-1] ? {1'b1, {(N-1){1'b0}}}
                       : {1'b0, {(N-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= 2'd3;
      r_win       <= 2'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_gnt       <= 4'b0;
      r_busy      <= 1'b0;
      r_out       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_id    <= 2'd0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req != 4'b0) begin
            r_a     <= a_bus[int'(w_win)*N +: N];
            r_b     <= b_bus[int'(w_win)*N +: N];
            r_sub   <= sub_bus[w_win];
            r_gnt   <= 4'b1 << w_win;
            r_last  <= w_win;
            r_win   <= w_win;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_gnt       <= 4'b0;
          r_out       <= w_res;
          r_cout      <= w_full[N];
          r_ovf       <= w_ovf;
          r_out_id    <= r_win;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_gnt       <= 4'b0;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign out       = r_out;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_id    = r_out_id;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: randomized and directed
// transactions against an arithmetic reference model.
module tb_addsub_arbiter;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic [3:0]     req;
  logic [4*N-1:0] a_bus;
  logic [4*N-1:0] b_bus;
  logic [3:0]     sub_bus;
  logic [3:0]     gnt;
  logic           busy;
  logic [N-1:0]   out;
  logic           cout;
  logic           ovf;
  logic [1:0]     out_id;
  logic           out_valid;
  logic           out_ready;

  addsub_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_bus(a_bus), .b_bus(b_bus), .sub_bus(sub_bus),
    .gnt(gnt), .busy(busy), .out(out), .cout(cout),
    .ovf(ovf), .out_id(out_id), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gcyc = 0;
  int mlast = 3;
  bit force_ready = 0;
  bit hold_ready = 0;
  logic [11:0] sb[$];
  int opa[4];
  int opb[4];
  int ops[4];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Expected {id, out, cout, ovf} from plain integer arithmetic.
  function automatic logic [11:0] model(int id, int a, int b, int s);
    int r, sa, sb_, sr, o;
    bit c, v;
    r  = s ? a - b : a + b;
    c  = s ? (a >= b) : (a + b > 255);
    sa = (a >= 128) ? a - 256 : a;
    sb_ = (b >= 128) ? b - 256 : b;
    sr = s ? sa - sb_ : sa + sb_;
    v  = (sr > 127) || (sr < -128);
    o  = r & 255;
`ifdef ADDSUB_ARB_SAT_EN
    if (v) o = (sr > 0) ? 127 : 128;
`endif
    return {id[1:0], o[7:0], c, v};
  endfunction

  task automatic start_req(input logic [3:0] mask, output int w);
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (mlast + k) % 4;
      if (w < 0 && mask[idx]) w = idx;
    end
    sb.push_back(model(w, opa[w], opb[w], ops[w]));
    mlast = w;
    for (int i = 0; i < 4; i++) begin
      a_bus[i*N +: N] = opa[i][7:0];
      b_bus[i*N +: N] = opb[i][7:0];
      sub_bus[i] = ops[i][0];
    end
    req = mask;
  endtask

  task automatic wait_gnt(input int w, input bit lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0 && n < 60);
    if (gnt == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout actual=0 required=%0h", 4'b1 << w);
    end else begin
      chk("gnt", gnt, 4'b1 << w);
      chk("busy_exec", busy, 1);
      gcyc = cyc;
      if (lat) begin
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("gnt_pulse", gnt, 0);
      end
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      opa[i] = $urandom_range(0, 255);
      opb[i] = $urandom_range(0, 255);
      ops[i] = $urandom_range(0, 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    force_ready = 1;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
    force_ready = 0;
  endtask

  // Monitor: chooses out_ready, pops on accept, checks hold stability.
  initial begin
    bit prev_hold;
    logic [11:0] prev_data, e;
    prev_hold = 0;
    prev_data = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 0;
        continue;
      end
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_id, out, cout, ovf}, prev_data);
      end
      out_ready = force_ready ? 1'b1 :
                  hold_ready  ? 1'b0 :
                  ($urandom_range(0, 3) != 0);
      prev_data = {out_id, out, cout, ovf};
      if (out_valid && out_ready) begin
        prev_hold = 0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h required=none",
                   prev_data);
        end else begin
          e = sb.pop_front();
          chk("result", prev_data, e);
        end
      end else begin
        prev_hold = out_valid;
      end
    end
  end

  initial begin
    int w, pg;
    rst = 1'b1;
    req = 4'b0;
    a_bus = '0;
    b_bus = '0;
    sub_bus = 4'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", {out, cout, ovf, out_id}, 0);
    chk("rst_valid", out_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fairness: all four held, ready high.
    rand_ops();
    force_ready = 1;
    pg = 0;
    for (int t = 0; t < 5; t++) begin
      start_req(4'b1111, w);
      chk("rr_order", w, t % 4);
      wait_gnt(w, 0);
      if (t > 0) chk("rr_spacing", gcyc - pg, 3);
      pg = gcyc;
    end
    req = 4'b0;
    drain();

    // Directed: subtract with borrow, requester 0.
    rand_ops();
    opa[0] = 5; opb[0] = 7; ops[0] = 1;
    start_req(4'b0001, w);
    wait_gnt(w, 1);
    req = 4'b0;
    drain();

    // Directed: signed overflow, requester 2.
    opa[2] = 100; opb[2] = 50; ops[2] = 0;
    start_req(4'b0100, w);
    wait_gnt(w, 1);
    req = 4'b0;
    drain();

    // Directed: wrap, requester 3.
    opa[3] = 255; opb[3] = 1; ops[3] = 0;
    start_req(4'b1000, w);
    wait_gnt(w, 1);
    req = 4'b0;
    drain();

    // Backpressure with requester 1 waiting.
    hold_ready = 1;
    rand_ops();
    start_req(4'b0001, w);
    wait_gnt(w, 1);
    req = 4'b0;
    start_req(4'b0010, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_no_gnt", gnt, 0);
      chk("bp_busy", busy, 1);
    end
    hold_ready = 0;
    force_ready = 1;
    wait_gnt(w, 1);
    req = 4'b0;
    drain();

    // Reset while in EXEC.
    rand_ops();
    start_req(4'b1111, w);
    wait_gnt(w, 0);
    req = 4'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_exec_valid", out_valid, 0);
    chk("rst_exec_busy", busy, 0);
    chk("rst_exec_gnt", gnt, 0);
    sb.delete();
    mlast = 3;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_regrant", gnt, 0);
    start_req(4'b1111, w);
    wait_gnt(w, 1);
    req = 4'b0;
    drain();

    // Randomized traffic with random backpressure.
    for (int t = 0; t < 40; t++) begin
      rand_ops();
      start_req(4'($urandom_range(1, 15)), w);
      wait_gnt(w, 1);
      req = 4'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=done", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one n-bit add/subtract datapath among four requesters. Each requester presents operands and an add/sub select with a level request. The block grants one requester, registers its operands, and computes a ± b with carry and signed-overflow flags. It returns the tagged result on a valid/ready output port. It sits between the arithmetic primitives and any multi-client logic that needs occasional two's-complement add/sub without a dedicated adder each.

## Interface
- n, 8, operand/result width in bits (n ≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  per-requester request, level; bit i = requester i
- a_bus  input  4n  requester i operand a at [i*n +: n]
- b_bus  input  4n  requester i operand b at [i*n +: n]
- sub_bus  input  4  requester i op select: 1 = a − b, 0 = a + b
- gnt  output  4  one-hot, one-cycle pulse: operands of that requester were captured
- busy  output  1  high whenever state ≠ IDLE
- out  output  n  result
- cout  output  1  carry out of MSB (for subtract: 1 = no borrow)
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)
- out_id  output  2  index of requester that owns out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result when high with out_valid

## Operation
- States: IDLE, EXEC, HOLD.
- IDLE:
  - If req ≠ 0 at a clock edge, select the winner by round-robin. Priority is last+1, last+2, last+3, last (mod 4).
  - On that edge: capture a, b, sub of the winner; set gnt to one-hot winner; update last to winner; go to EXEC.
  - If req = 0, remain in IDLE.
- EXEC:
  - gnt is high this cycle only.
  - On the edge: compute out = a + (b XOR {n{sub}}) + sub, modulo 2^n. Register out, cout, ovf, out_id = winner. Set out_valid = 1; go to HOLD.
- HOLD:
  - out, cout, ovf, out_id and out_valid remain stable while out_ready = 0.
  - On an edge with out_ready = 1: clear out_valid; go to IDLE.
- req is not sampled in EXEC or HOLD.
- A requester must deassert req in the cycle it sees its gnt bit. If req is still high at the next IDLE sample, it counts as a new request.
- Operands need to be stable only in the IDLE cycle in which they are sampled.
- Flags are computed on the full n-bit values. Operand 0 and the all-ones operand wrap normally.
- Reset values: state IDLE, last = 3 (requester 0 has first priority), gnt = 0, busy = 0, out = 0, cout = 0, ovf = 0, out_id = 0, out_valid = 0.
- Reset asserted mid-operation aborts the transaction immediately. The result is discarded and no re-grant is issued.

## Timing
- Request sampled at edge k → gnt high in cycle k..k+1 → out_valid high from edge k+1.
- Minimum of 3 cycles per operation when out_ready is held high: IDLE, EXEC, HOLD.
- out_ready is ignored unless out_valid = 1.
- Simultaneous requests:
  - Exactly one grant per arbitration.
  - Under continuous requests from all four requesters, grant order is 0,1,2,3,0,…
  - A single requester may win back-to-back when no other requester is active.
- Outputs are registered. No combinational path from inputs to outputs.

## Configuration
- ADDSUB_ARB_SAT_EN defined: when ovf = 1, out saturates to the signed limit. The limit is 2^(n−1)−1 if the true result is positive, −2^(n−1) if it is negative. cout and ovf are still reported unmodified.
- ADDSUB_ARB_SAT_EN undefined: out is the wrapped modulo-2^n result.

## Test plan
- Single requester, n = 8: req = 0001, a0 = 5, b0 = 7, sub0 = 1 → gnt = 0001 one cycle; out = 0xFE, cout = 0, ovf = 0, out_id = 0, out_valid one cycle later.
- Overflow: requester 2, a = 100, b = 50, add → out = 0x96, cout = 0, ovf = 1, out_id = 2. With ADDSUB_ARB_SAT_EN → out = 0x7F, ovf = 1.
- Fairness: req = 1111 held continuously, out_ready = 1 → gnt sequence 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles.
- Backpressure: result pending, out_ready = 0 for 5 cycles with req = 0010 → out and flags stable, no gnt. Raising out_ready → out_valid drops next edge, then requester 1 is granted.
- Reset during EXEC: rst pulse → out_valid = 0, busy = 0, gnt = 0 immediately. The next arbitration with req = 1111 grants requester 0.
- Wrap: a = 0xFF, b = 0x01, add → out = 0x00, cout = 1, ovf = 0.
